bp_me_stream_pump_in: RTL and testbench



---
 rtl/bp_me_stream_pump_in_if.sv | 43 ++++
 rtl/bp_me_stream_pump_in.sv | 138 +++++++++++++
 tb/tb_bp_me_stream_pump_in.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_me_stream_pump_in_if.sv
// Receive-side stream pump bundle: BedRock stream input on one side, per-beat FSM view on the other.
// Header layout, LSB first: msg_type[3:0], size[2:0] (log2 bytes), addr, payload.
interface bp_me_stream_pump_in_if #(
  parameter int unsigned paddr_width_p       = 40,
  parameter int unsigned stream_data_width_p = 64,
  parameter int unsigned block_width_p       = 512,
  parameter int unsigned payload_width_p     = 16
);
  localparam int unsigned HdrW = payload_width_p + paddr_width_p + 7;
  localparam int unsigned W    = block_width_p / stream_data_width_p;
  localparam int unsigned CW   = (W > 1) ? $clog2(W) : 1;

  logic [HdrW-1:0]                msg_header_i;
  logic                           msg_header_v_i;
  logic                           msg_header_ready_and_o;
  logic                           msg_has_data_i;
  logic [stream_data_width_p-1:0] msg_data_i;
  logic                           msg_data_v_i;
  logic                           msg_data_ready_and_o;
  logic                           msg_last_i;
  logic [HdrW-1:0]                fsm_base_header_o;
  logic [paddr_width_p-1:0]       fsm_addr_o;
  logic [stream_data_width_p-1:0] fsm_data_o;
  logic                           fsm_v_o;
  logic                           fsm_ready_and_i;
  logic [CW-1:0]                  fsm_cnt_o;
  logic                           fsm_new_o;
  logic                           fsm_last_o;

  modport slave (
    input  msg_header_i, msg_header_v_i, msg_has_data_i, msg_data_i, msg_data_v_i, msg_last_i,
           fsm_ready_and_i,
    output msg_header_ready_and_o, msg_data_ready_and_o, fsm_base_header_o, fsm_addr_o,
           fsm_data_o, fsm_v_o, fsm_cnt_o, fsm_new_o, fsm_last_o
  );

  modport master (
    output msg_header_i, msg_header_v_i, msg_has_data_i, msg_data_i, msg_data_v_i, msg_last_i,
           fsm_ready_and_i,
    input  msg_header_ready_and_o, msg_data_ready_and_o, fsm_base_header_o, fsm_addr_o,
           fsm_data_o, fsm_v_o, fsm_cnt_o, fsm_new_o, fsm_last_o
  );
endinterface

// File: rtl/bp_me_stream_pump_in.sv
// Receive-side BedRock stream pump: latches a header, then presents the message to a consumer FSM
// one beat at a time with wrapped per-beat address, word count and first/last strobes.
module bp_me_stream_pump_in #(
  parameter int unsigned paddr_width_p       = 40,
  parameter int unsigned stream_data_width_p = 64,
  parameter int unsigned block_width_p       = 512,
  parameter int unsigned payload_width_p     = 16,
  parameter logic [15:0] fsm_stream_mask_p   = 16'h0000
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  bp_me_stream_pump_in_if.slave io
);
  localparam int unsigned HdrW    = payload_width_p + paddr_width_p + 7;
  localparam int unsigned SB      = stream_data_width_p / 8;
  localparam int unsigned W       = block_width_p / stream_data_width_p;
  localparam int unsigned CW      = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned OW      = (SB > 1) ? $clog2(SB) : 1;
  localparam int unsigned LgSb    = $clog2(SB);
  localparam int unsigned LgW     = $clog2(W);
  localparam int unsigned SizeLsb = 4;
  localparam int unsigned AddrLsb = 7;

  typedef enum logic [1:0] {StReady, StStream, StDrain} state_e;

  state_e          state_q;
  logic [HdrW-1:0] hdr_q;
  logic            hd_q;
  logic            fs_q;
  logic [CW-1:0]   cnt_q;

  logic [2:0]               hdr_size;
  logic [paddr_width_p-1:0] hdr_addr;
  logic [CW-1:0]            start_idx;
  logic [CW-1:0]            bmask;
  logic [CW-1:0]            cnt_idx;
  logic [paddr_width_p-1:0] beat_addr;
  int unsigned              lg_beats;
  logic                     in_stream;
  logic                     fsm_last;
  logic                     fsm_v;
  logic                     fsm_xfer;
  logic                     data_rdy;
  logic [stream_data_width_p-1:0] fsm_data;

  assign hdr_size  = hdr_q[SizeLsb +: 3];
  assign hdr_addr  = hdr_q[AddrLsb +: paddr_width_p];
  assign start_idx = hdr_addr[OW +: CW];
  assign in_stream = (state_q == StStream);

  // log2 of the beat count: whole-message size in stream words, clamped to one block
  always_comb begin
    lg_beats = 0;
    if (fs_q && (32'(hdr_size) > LgSb)) lg_beats = 32'(hdr_size) - LgSb;
    if (lg_beats > LgW) lg_beats = LgW;
  end

  assign bmask   = CW'((32'd1 << lg_beats) - 32'd1);
  assign cnt_idx = (start_idx & ~bmask) | ((start_idx + cnt_q) & bmask);

  // Sub-word offset is only meaningful for the critical (first) beat
  always_comb begin
    beat_addr             = hdr_addr;
    beat_addr[OW +: CW]   = cnt_idx;
    if (cnt_q != '0) beat_addr[OW-1:0] = '0;
  end

  assign fsm_last = (cnt_q == bmask);

  always_comb begin
    fsm_v    = 1'b0;
    fsm_data = '0;
    data_rdy = 1'b0;
    unique case (state_q)
      StStream: begin
        if (hd_q) begin
          fsm_v    = io.msg_data_v_i;
          fsm_data = io.msg_data_i;
          data_rdy = io.fsm_ready_and_i;
        end else begin
          fsm_v = 1'b1;
        end
      end
      StDrain: data_rdy = 1'b1;
      default: ;
    endcase
  end

  assign fsm_xfer = fsm_v && io.fsm_ready_and_i;

  assign io.msg_header_ready_and_o = reset_n_i && (state_q == StReady);
  assign io.msg_data_ready_and_o   = data_rdy;
  assign io.fsm_base_header_o      = hdr_q;
  assign io.fsm_addr_o             = beat_addr;
  assign io.fsm_data_o             = fsm_data;
  assign io.fsm_v_o                = fsm_v;
  assign io.fsm_cnt_o              = cnt_idx;
  assign io.fsm_new_o              = in_stream && (cnt_q == '0);
  assign io.fsm_last_o             = in_stream && fsm_last;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StReady;
      hdr_q   <= '0;
      hd_q    <= 1'b0;
      fs_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StReady: begin
          if (io.msg_header_v_i) begin
            hdr_q   <= io.msg_header_i;
            hd_q    <= io.msg_has_data_i;
            fs_q    <= fsm_stream_mask_p[io.msg_header_i[3:0]];
            cnt_q   <= '0;
            state_q <= StStream;
          end
        end
        StStream: begin
          if (fsm_xfer) begin
            cnt_q <= cnt_q + 1'b1;
            // N:1 hands only the first data beat to the FSM; the rest are dropped
            if (hd_q && !fs_q) state_q <= io.msg_last_i ? StReady : StDrain;
            else if (fsm_last) state_q <= StReady;
          end
        end
        StDrain: begin
          if (io.msg_data_v_i && io.msg_last_i) state_q <= StReady;
        end
        default: state_q <= StReady;
      endcase
    end
  end

  a_nn_last_aligned: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (in_stream && hd_q && fs_q && io.msg_data_v_i && io.fsm_ready_and_i)
      |-> (io.msg_last_i == fsm_last));
endmodule

// File: tb/tb_bp_me_stream_pump_in.sv
// Bench for bp_me_stream_pump_in: directed vector table, reset/back-to-back sequences and
// randomized messages checked against an arithmetic per-beat address model.
module tb_bp_me_stream_pump_in;
  localparam int unsigned PaddrW   = 40;
  localparam int unsigned DataW    = 64;
  localparam int unsigned BlockW   = 512;
  localparam int unsigned PayloadW = 16;
  localparam logic [15:0] Mask     = 16'h0003;
  localparam int unsigned SB       = 8;
  localparam int unsigned W        = 8;

  typedef struct {
    int unsigned     typ;
    int unsigned     size;
    longint unsigned addr;
    bit              hd;
    int unsigned     nmsg;
    int unsigned     exp_beats;
    longint unsigned exp_cnt0;
    longint unsigned exp_addr_last;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bp_me_stream_pump_in_if #(
    .paddr_width_p(PaddrW), .stream_data_width_p(DataW),
    .block_width_p(BlockW), .payload_width_p(PayloadW)
  ) bus ();

  bp_me_stream_pump_in #(
    .paddr_width_p(PaddrW), .stream_data_width_p(DataW), .block_width_p(BlockW),
    .payload_width_p(PayloadW), .fsm_stream_mask_p(Mask)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .io(bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned model_beats(int unsigned typ, int unsigned size);
    int unsigned b;
    if (!Mask[typ]) return 1;
    b = (1 << size) / SB;
    if (b < 1) b = 1;
    if (b > W) b = W;
    return b;
  endfunction

  function automatic longint unsigned model_cnt(longint unsigned addr, int unsigned b,
                                                int unsigned i);
    longint unsigned w0 = (addr / SB) % W;
    return (w0 / b) * b + (w0 + i) % b;
  endfunction

  function automatic longint unsigned model_addr(longint unsigned addr, int unsigned b,
                                                 int unsigned i);
    longint unsigned base = addr - addr % (W * SB);
    return base + model_cnt(addr, b, i) * SB + ((i == 0) ? addr % SB : 0);
  endfunction

  function automatic logic [62:0] mk_hdr(int unsigned typ, int unsigned size,
                                         longint unsigned addr);
    logic [15:0] pl = 16'($urandom);
    return {pl, addr[39:0], size[2:0], typ[3:0]};
  endfunction

  task automatic idle();
    bus.msg_header_i    = '0;
    bus.msg_header_v_i  = 1'b0;
    bus.msg_has_data_i  = 1'b0;
    bus.msg_data_i      = '0;
    bus.msg_data_v_i    = 1'b0;
    bus.msg_last_i      = 1'b0;
    bus.fsm_ready_and_i = 1'b0;
  endtask

  task automatic run_msg(input int unsigned typ, input int unsigned size,
                         input longint unsigned addr, input bit hd, input int unsigned nmsg,
                         output int unsigned nf, output longint unsigned cnt0,
                         output longint unsigned alast);
    logic [62:0] hdr;
    logic [63:0] d [8];
    int unsigned b, mi, cyc, k;
    bit fs, fx, mx;
    fs = Mask[typ];
    b = model_beats(typ, size);
    hdr = mk_hdr(typ, size, addr);
    for (int i = 0; i < 8; i++) d[i] = {$urandom, $urandom};
    nf = 0; mi = 0; cyc = 0; k = 0; cnt0 = 0; alast = 0;
    @(negedge clk);
    bus.msg_header_i   = hdr;
    bus.msg_header_v_i = 1'b1;
    bus.msg_has_data_i = hd;
    #1;
    while (!bus.msg_header_ready_and_o && k < 50) begin
      @(negedge clk); #1; k++;
    end
    chk("hdr_accept", bus.msg_header_ready_and_o, 1);
    @(negedge clk);
    bus.msg_header_v_i = 1'b0;
    bus.msg_has_data_i = 1'($urandom);
    bus.msg_header_i   = mk_hdr($urandom_range(3), $urandom_range(6), $urandom);
    while ((nf < b || mi < nmsg) && cyc < 400) begin
      bus.msg_data_v_i    = (mi < nmsg) && ($urandom_range(3) != 0);
      bus.msg_data_i      = d[mi % 8];
      bus.msg_last_i      = (mi + 1 == nmsg);
      bus.fsm_ready_and_i = ($urandom_range(2) != 0);
      #1;
      chk("hdr_rdy_busy", bus.msg_header_ready_and_o, 0);
      fx = bus.fsm_v_o && bus.fsm_ready_and_i;
      mx = bus.msg_data_v_i && bus.msg_data_ready_and_o;
      if (!hd) chk("data_rdy_nodata", bus.msg_data_ready_and_o, 0);
      if (fx) begin
        chk("fsm_extra_beat", nf < b, 1);
        chk("fsm_cnt", bus.fsm_cnt_o, model_cnt(addr, b, nf));
        chk("fsm_addr", bus.fsm_addr_o, model_addr(addr, b, nf));
        chk("fsm_new", bus.fsm_new_o, nf == 0);
        chk("fsm_last", bus.fsm_last_o, nf == b - 1);
        chk("fsm_data", bus.fsm_data_o, hd ? d[nf % 8] : 64'h0);
        chk("base_hdr", bus.fsm_base_header_o, hdr);
        if (hd && fs) chk("nn_pair", mx, 1);
        if (nf == 0) cnt0 = bus.fsm_cnt_o;
        alast = bus.fsm_addr_o;
        nf++;
      end
      if (mx) mi++;
      @(negedge clk);
      cyc++;
    end
    idle();
    #1;
    chk("fsm_beats", nf, b);
    chk("msg_beats", mi, nmsg);
    chk("hdr_rdy_after", bus.msg_header_ready_and_o, 1);
    chk("fsm_v_after", bus.fsm_v_o, 0);
  endtask

  initial begin
    vec_t vecs [6];
    int unsigned nf, b, nmsg, typ, size, acc, beats;
    longint unsigned cnt0, alast, addr, a_cur, a_prev;
    logic [62:0] hdr;
    bit hx, fx, prev_hx;

    vecs[0] = '{0, 6, 64'h1010, 1'b0, 0, 8, 2, 64'h1008};
    vecs[1] = '{1, 6, 64'h2000, 1'b1, 8, 8, 0, 64'h2038};
    vecs[2] = '{2, 6, 64'h3000, 1'b1, 8, 1, 0, 64'h3000};
    vecs[3] = '{1, 3, 64'h4028, 1'b1, 1, 1, 5, 64'h4028};
    vecs[4] = '{0, 5, 64'h5034, 1'b0, 0, 4, 6, 64'h5028};
    vecs[5] = '{3, 6, 64'h6008, 1'b0, 0, 1, 1, 64'h6008};

    idle();
    #1 rst_n = 1'b0;
    #2;
    chk("rst_hdr_rdy", bus.msg_header_ready_and_o, 0);
    chk("rst_data_rdy", bus.msg_data_ready_and_o, 0);
    chk("rst_fsm_v", bus.fsm_v_o, 0);
    chk("rst_new", bus.fsm_new_o, 0);
    chk("rst_last", bus.fsm_last_o, 0);
    chk("rst_base_hdr", bus.fsm_base_header_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_hdr_rdy", bus.msg_header_ready_and_o, 1);

    foreach (vecs[i]) begin
      run_msg(vecs[i].typ, vecs[i].size, vecs[i].addr, vecs[i].hd, vecs[i].nmsg,
              nf, cnt0, alast);
      chk($sformatf("vec%0d_beats", i), nf, vecs[i].exp_beats);
      chk($sformatf("vec%0d_cnt0", i), cnt0, vecs[i].exp_cnt0);
      chk($sformatf("vec%0d_addr_last", i), alast, vecs[i].exp_addr_last);
    end

    // Asynchronous reset in the middle of an N:N write
    @(negedge clk);
    bus.msg_header_i   = mk_hdr(1, 6, 64'h2000);
    bus.msg_header_v_i = 1'b1;
    bus.msg_has_data_i = 1'b1;
    #1 chk("rst5_hdr_accept", bus.msg_header_ready_and_o, 1);
    @(negedge clk);
    bus.msg_header_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.msg_data_v_i    = 1'b1;
      bus.msg_data_i      = 64'(i + 1);
      bus.msg_last_i      = 1'b0;
      bus.fsm_ready_and_i = 1'b1;
      @(negedge clk);
    end
    #1 chk("rst5_pre_cnt", bus.fsm_cnt_o, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst5_fsm_v", bus.fsm_v_o, 0);
    chk("rst5_data_rdy", bus.msg_data_ready_and_o, 0);
    chk("rst5_hdr_rdy", bus.msg_header_ready_and_o, 0);
    chk("rst5_cnt", bus.fsm_cnt_o, 0);
    chk("rst5_addr", bus.fsm_addr_o, 0);
    chk("rst5_data", bus.fsm_data_o, 0);
    chk("rst5_base_hdr", bus.fsm_base_header_o, 0);
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst5_post_hdr_rdy", bus.msg_header_ready_and_o, 1);
    run_msg(1, 6, 64'h2008, 1'b1, 8, nf, cnt0, alast);
    chk("rst5_after_cnt0", cnt0, 1);

    // Back-to-back headers with valid held high
    acc = 0; beats = 0; prev_hx = 1'b0; a_prev = 0;
    a_cur = 64'h7000;
    hdr = mk_hdr(3, 6, a_cur);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      bus.msg_header_i    = hdr;
      bus.msg_header_v_i  = 1'b1;
      bus.msg_has_data_i  = 1'b0;
      bus.fsm_ready_and_i = 1'b1;
      #1;
      hx = bus.msg_header_v_i && bus.msg_header_ready_and_o;
      fx = bus.fsm_v_o && bus.fsm_ready_and_i;
      if (fx) begin
        chk("b2b_addr", bus.fsm_addr_o, a_prev);
        beats++;
      end
      if (hx) begin
        chk("b2b_gap", prev_hx, 0);
        a_prev = a_cur;
        acc++;
        a_cur = 64'h7000 + acc * 64'h48;
        hdr = mk_hdr(3, 6, a_cur);
      end
      prev_hx = hx;
      @(negedge clk);
    end
    idle();
    chk("b2b_hdrs", acc, 10);
    chk("b2b_beats", beats, 10);

    for (int r = 0; r < 40; r++) begin
      typ  = $urandom_range(3);
      size = $urandom_range(6);
      addr = longint'($urandom);
      b    = model_beats(typ, size);
      nmsg = (typ == 1) ? b : (typ == 2) ? $urandom_range(8, 1) : 0;
      run_msg(typ, size, addr, (typ == 1 || typ == 2), nmsg, nf, cnt0, alast);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
